me_run_sequencer: RTL and testbench
===================================

Name: me_run_sequencer

Overview:
- FPGA-side control block between the board pushbuttons and the motion-estimation core.
- Debounces start, stop and mode buttons.
- Drives the core with a 4-phase req/ack handshake, in single-shot or continuous mode.
- Measures per-run latency and keeps a circular history of the last HIST_DEPTH results, with one entry at a time selectable for the 7-segment display.

Parameters:
- CNT_WIDTH, 12, width of min_cnt from the ME core.
- SAD_WIDTH, 16, width of min_sad from the ME core.
- CYC_WIDTH, 24, width of the per-run latency counter (saturating).
- HIST_DEPTH, 8, number of history entries; power of two, ≥2.
- DEBOUNCE_CYCLES, 100000, cycles an input must be stable before its debounced value changes.
- TIMEOUT_CYCLES, 2**20, maximum RUN cycles before abort with error.

Ports:
- RSTN  in  1  asynchronous active-low reset
- clk  in  1  clock
- sw_start_n  in  1  raw pushbutton, active-low, asynchronous
- sw_stop_n  in  1  raw pushbutton, active-low, asynchronous
- sw_mode_n  in  1  raw pushbutton, active-low, asynchronous; toggles mode
- me_req  out  1  request to ME core
- me_ack  in  1  acknowledge from ME core (same clk domain)
- me_min_cnt  in  CNT_WIDTH  ME result index, valid while me_ack=1
- me_min_sad  in  SAD_WIDTH  ME result SAD, valid while me_ack=1
- hist_sel  in  log2(HIST_DEPTH)  history index; 0 = newest
- hist_cnt  out  CNT_WIDTH  selected entry min_cnt
- hist_sad  out  SAD_WIDTH  selected entry min_sad
- hist_cyc  out  CYC_WIDTH  selected entry latency
- hist_fill  out  log2(HIST_DEPTH)+1  valid entries, saturates at HIST_DEPTH
- run_count  out  16  completed runs, wraps at 2**16
- busy  out  1  FSM not in IDLE
- mode_cont  out  1  1 = continuous mode
- err_timeout  out  1  sticky timeout flag; cleared by the next start press
- hist_wrapped  out  1  sticky; set when a history entry is overwritten

Behaviour:
- Reset is asynchronous. All outputs and state go to 0 on reset, including me_req. FSM enters IDLE and history is emptied. Reset mid-run drops me_req immediately with no capture.
- Each button passes through a 2-FF synchroniser, then a debounce counter. The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. A 1→0 transition of the debounced level produces a one-cycle press pulse. Debounced levels reset to 1.
- A mode press toggles mode_cont in any state. The new mode takes effect at the next RELEASE exit.
- FSM states are IDLE, RUN, RELEASE.
- IDLE:
  - start press and no stop press in the same cycle → RUN, me_req←1, cyc←0, err_timeout←0.
  - Simultaneous start and stop presses: stay in IDLE.
- RUN:
  - Priority order: stop > ack > timeout.
  - stop press → me_req←0, no capture, → RELEASE with stop_pend←1.
  - me_ack=1 → capture {me_min_cnt, me_min_sad, cyc} at wr_ptr; wr_ptr++ (wraps); hist_fill++ (saturating); if hist_fill was already HIST_DEPTH, set hist_wrapped; run_count++; me_req←0; → RELEASE.
  - Else if cyc = TIMEOUT_CYCLES−1 → err_timeout←1, me_req←0, → RELEASE.
  - Else cyc++, saturating at all-ones.
  - The captured cyc equals the number of RUN edges on which me_ack was sampled 0.
- RELEASE:
  - me_req=0. A stop press here sets stop_pend.
  - On me_ack=0: if mode_cont=1, stop_pend=0 and err_timeout=0 → RUN (me_req←1, cyc←0). Otherwise → IDLE.
  - stop_pend clears on leaving RELEASE.
- me_req never rises while me_ack=1.
- History read is registered: hist_cnt/hist_sad/hist_cyc reflect entry (wr_ptr−1−hist_sel) mod HIST_DEPTH one cycle after any change of hist_sel or a write. If hist_sel ≥ hist_fill, the outputs read 0.
- busy = (state ≠ IDLE).

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, HIST_DEPTH=4; ME stub raises ack N cycles after req and holds it until req falls):
- Debounce: 2-cycle glitch on sw_start_n → no run. Clean 10-cycle press → exactly one run; me_req rises 1 cycle after the press pulse.
- Single shot: stub N=20, result (cnt=0x123, sad=0x0456) → hist_sel=0 reads 0x123/0x0456/cyc=20; run_count=1; FSM returns to IDLE; me_req stays 0.
- Continuous: mode press, start press, stub N=5 with distinct results → 6 back-to-back runs. hist_fill=4, hist_wrapped=1, hist_sel=3 reads the 3rd result. A stop press during RUN → no capture, IDLE after ack low.
- Timeout: stub never acks → me_req falls after 64 RUN cycles; err_timeout=1; no capture. Continuous mode does not restart. The next start press clears the flag.
- Simultaneous start+stop in IDLE → stays IDLE. hist_sel=2 with hist_fill=1 → outputs 0.
- Reset asserted mid-RUN → me_req=0 asynchronously; all outputs 0; after release, FSM is in IDLE.

Source files
------------

// File: rtl/me_run_sequencer.sv
// ---------------------------------------------------------------------------
// me_run_sequencer: debounced button control of the ME core req/ack handshake,
// with per-run latency capture into a circular result history.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module me_run_sequencer #(
  parameter int CNT_WIDTH       = 12,
  parameter int SAD_WIDTH       = 16,
  parameter int CYC_WIDTH       = 24,
  parameter int HIST_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES  = 2**20
) (
  input  logic                          RSTN,
  input  logic                          clk,
  input  logic                          sw_start_n,
  input  logic                          sw_stop_n,
  input  logic                          sw_mode_n,
  output logic                          me_req,
  input  logic                          me_ack,
  input  logic [CNT_WIDTH-1:0]          me_min_cnt,
  input  logic [SAD_WIDTH-1:0]          me_min_sad,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_sel,
  output logic [CNT_WIDTH-1:0]          hist_cnt,
  output logic [SAD_WIDTH-1:0]          hist_sad,
  output logic [CYC_WIDTH-1:0]          hist_cyc,
  output logic [$clog2(HIST_DEPTH):0]   hist_fill,
  output logic [15:0]                   run_count,
  output logic                          busy,
  output logic                          mode_cont,
  output logic                          err_timeout,
  output logic                          hist_wrapped
);

  localparam int c_HW  = $clog2(HIST_DEPTH);
  localparam int c_DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CYC_WIDTH-1:0] c_TO_LAST = CYC_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  logic [2:0] w_raw;
  logic [2:0] w_press;
  assign w_raw = {sw_mode_n, sw_stop_n, sw_start_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic             r_s1, r_s2, r_db, r_pulse;
    logic [c_DBW-1:0] r_cnt;
    // Debounced level idles high; a pulse marks only its falling transition.
    always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
        r_s1    <= 1'b1;
        r_s2    <= 1'b1;
        r_db    <= 1'b1;
        r_pulse <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_raw[gi];
        r_s2    <= r_s1;
        r_pulse <= 1'b0;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db    <= r_s2;
          r_cnt   <= '0;
          r_pulse <= r_db;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
    assign w_press[gi] = r_pulse;
  end

  logic w_start, w_stop, w_mode;
  assign w_start = w_press[0];
  assign w_stop  = w_press[1];
  assign w_mode  = w_press[2];

  state_t                 r_state, w_state_nxt;
  logic                   r_req, w_req_nxt;
  logic                   r_stop_pend, w_pend_nxt;
  logic [CYC_WIDTH-1:0]   r_cyc;
  logic                   r_err, r_mode, r_wrapped;
  logic [15:0]            r_runs;
  logic [c_HW-1:0]        r_wr_ptr;
  logic [c_HW:0]          r_fill;
  logic                   w_capture, w_cyc_clr, w_cyc_inc, w_to_set, w_to_clr;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_pend_nxt  = r_stop_pend;
    w_capture   = 1'b0;
    w_cyc_clr   = 1'b0;
    w_cyc_inc   = 1'b0;
    w_to_set    = 1'b0;
    w_to_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_nxt = 1'b0;
        // Holding off while ack is still high keeps req from rising into it.
        if (w_start && !w_stop && !me_ack) begin
          w_state_nxt = S_RUN;
          w_req_nxt   = 1'b1;
          w_cyc_clr   = 1'b1;
          w_to_clr    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_req_nxt   = 1'b0;
          w_pend_nxt  = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (me_ack) begin
          w_capture   = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_RELEASE;
        end else if (r_cyc == c_TO_LAST) begin
          w_to_set    = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_RELEASE;
        end else begin
          w_cyc_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        w_req_nxt = 1'b0;
        if (w_stop) w_pend_nxt = 1'b1;
        if (!me_ack) begin
          w_pend_nxt = 1'b0;
          if (r_mode && !r_stop_pend && !w_stop && !r_err) begin
            w_state_nxt = S_RUN;
            w_req_nxt   = 1'b1;
            w_cyc_clr   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_cyc       <= '0;
      r_err       <= 1'b0;
      r_mode      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_stop_pend <= w_pend_nxt;
      r_mode      <= r_mode ^ w_mode;
      if (w_cyc_clr)                      r_cyc <= '0;
      else if (w_cyc_inc && r_cyc != '1)  r_cyc <= r_cyc + 1'b1;
      if (w_to_clr)      r_err <= 1'b0;
      else if (w_to_set) r_err <= 1'b1;
    end
  end

  logic [CNT_WIDTH-1:0] r_h_cnt [HIST_DEPTH];
  logic [SAD_WIDTH-1:0] r_h_sad [HIST_DEPTH];
  logic [CYC_WIDTH-1:0] r_h_cyc [HIST_DEPTH];

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_h_cnt[i] <= '0;
        r_h_sad[i] <= '0;
        r_h_cyc[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_wrapped <= 1'b0;
      r_runs    <= '0;
    end else if (w_capture) begin
      r_h_cnt[r_wr_ptr] <= me_min_cnt;
      r_h_sad[r_wr_ptr] <= me_min_sad;
      r_h_cyc[r_wr_ptr] <= r_cyc;
      r_wr_ptr          <= r_wr_ptr + 1'b1;
      r_runs            <= r_runs + 16'd1;
      if (r_fill == (c_HW+1)'(HIST_DEPTH)) r_wrapped <= 1'b1;
      else                                 r_fill    <= r_fill + 1'b1;
    end
  end

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  logic [c_HW-1:0]      w_rd_idx;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic [SAD_WIDTH-1:0] r_rd_sad;
  logic [CYC_WIDTH-1:0] r_rd_cyc;
  assign w_rd_idx = r_wr_ptr - c_HW'(1) - hist_sel;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_cnt <= '0;
      r_rd_sad <= '0;
      r_rd_cyc <= '0;
    end else if ({1'b0, hist_sel} < r_fill) begin
      r_rd_cnt <= r_h_cnt[w_rd_idx];
      r_rd_sad <= r_h_sad[w_rd_idx];
      r_rd_cyc <= r_h_cyc[w_rd_idx];
    end else begin
      r_rd_cnt <= '0;
      r_rd_sad <= '0;
      r_rd_cyc <= '0;
    end
  end

  assign me_req       = r_req;
  assign busy         = (r_state != S_IDLE);
  assign mode_cont    = r_mode;
  assign err_timeout  = r_err;
  assign hist_wrapped = r_wrapped;
  assign hist_fill    = r_fill;
  assign run_count    = r_runs;
  assign hist_cnt     = r_rd_cnt;
  assign hist_sad     = r_rd_sad;
  assign hist_cyc     = r_rd_cyc;

endmodule

`default_nettype wire

// File: tb/tb_me_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_me_run_sequencer: directed bench with ME stub and queue-based history model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_me_run_sequencer;

  localparam int HD = 4;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        sw_start_n = 1'b1, sw_stop_n = 1'b1, sw_mode_n = 1'b1;
  logic        me_req;
  logic        me_ack = 1'b0;
  logic [11:0] me_min_cnt = 12'hFFF;
  logic [15:0] me_min_sad = 16'hFFFF;
  logic [1:0]  hist_sel = 2'd0;
  logic [11:0] hist_cnt;
  logic [15:0] hist_sad;
  logic [23:0] hist_cyc;
  logic [2:0]  hist_fill;
  logic [15:0] run_count;
  logic        busy, mode_cont, err_timeout, hist_wrapped;

  always #5 clk = ~clk;

  me_run_sequencer #(
    .CNT_WIDTH(12), .SAD_WIDTH(16), .CYC_WIDTH(24), .HIST_DEPTH(HD),
    .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .RSTN(RSTN), .clk(clk),
    .sw_start_n(sw_start_n), .sw_stop_n(sw_stop_n), .sw_mode_n(sw_mode_n),
    .me_req(me_req), .me_ack(me_ack), .me_min_cnt(me_min_cnt), .me_min_sad(me_min_sad),
    .hist_sel(hist_sel), .hist_cnt(hist_cnt), .hist_sad(hist_sad), .hist_cyc(hist_cyc),
    .hist_fill(hist_fill), .run_count(run_count), .busy(busy), .mode_cont(mode_cont),
    .err_timeout(err_timeout), .hist_wrapped(hist_wrapped)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ME stub: ack rises once req has been high for n_ack+1 falling edges,
  // so the core sees n_ack zero-ack cycles; results advance after each ack.
  int          n_ack = 3;
  bit          never_ack = 1'b0;
  logic [11:0] cur_cnt = 12'h000;
  logic [15:0] cur_sad = 16'h0000;
  int          k = 0;

  always @(negedge clk) begin
    if (!RSTN || !me_req) begin
      if (me_ack) begin
        cur_cnt = cur_cnt + 12'd1;
        cur_sad = cur_sad + 16'd1;
      end
      k          = 0;
      me_ack     = 1'b0;
      me_min_cnt = 12'hFFF;
      me_min_sad = 16'hFFFF;
    end else begin
      k++;
      if (!never_ack && k > n_ack && !me_ack) begin
        me_ack     = 1'b1;
        me_min_cnt = cur_cnt;
        me_min_sad = cur_sad;
      end
    end
  end

  logic        s_req = 1'b0, s_ack = 1'b0;
  logic [11:0] s_cnt;
  logic [15:0] s_sad;
  always @(posedge clk) begin
    s_req = me_req;
    s_ack = me_ack;
    s_cnt = me_min_cnt;
    s_sad = me_min_sad;
  end

  // Model: a completed handshake pushes a result to the front of a queue
  // bounded at HD entries; read outputs lag the queue and hist_sel by a cycle.
  typedef struct packed {
    logic [11:0] c;
    logic [15:0] s;
    logic [23:0] y;
  } ent_t;

  ent_t        m_q[$];
  ent_t        snap_q[$];
  logic [15:0] m_runs = 16'd0;
  bit          m_wrap = 1'b0;
  logic [1:0]  snap_sel = 2'd0;
  bit          snap_ok = 1'b0;
  bit          prev_req = 1'b0;
  int          req_rises = 0, cur_len = 0, last_len = 0;

  always @(negedge clk) begin : compare
    ent_t e;
    if (!RSTN) begin
      m_q.delete();
      snap_q.delete();
      m_runs    = 16'd0;
      m_wrap    = 1'b0;
      snap_ok   = 1'b0;
      prev_req  = 1'b0;
      req_rises = 0;
      cur_len   = 0;
      last_len  = 0;
    end else begin
      if (s_req && s_ack) begin
        e.c = s_cnt;
        e.s = s_sad;
        e.y = 24'(n_ack);
        m_q.push_front(e);
        if (m_q.size() > HD) begin
          void'(m_q.pop_back());
          m_wrap = 1'b1;
        end
        m_runs = m_runs + 16'd1;
      end
      chk("run_count", 32'(run_count), 32'(m_runs));
      chk("hist_fill", 32'(hist_fill), m_q.size());
      chk("hist_wrapped", 32'(hist_wrapped), 32'(m_wrap));
      if (snap_ok) begin
        if (int'(snap_sel) < snap_q.size()) e = snap_q[snap_sel];
        else                                e = '0;
        chk("hist_cnt", 32'(hist_cnt), 32'(e.c));
        chk("hist_sad", 32'(hist_sad), 32'(e.s));
        chk("hist_cyc", 32'(hist_cyc), 32'(e.y));
      end
      snap_q   = m_q;
      snap_sel = hist_sel;
      snap_ok  = 1'b1;
      if (me_req && !prev_req) req_rises++;
      if (me_req) cur_len++;
      else if (cur_len > 0) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      prev_req = me_req;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_me_req"}, 32'(me_req), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_run_count"}, 32'(run_count), 0);
    chk({tag, "_hist_fill"}, 32'(hist_fill), 0);
    chk({tag, "_hist_wrapped"}, 32'(hist_wrapped), 0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
    chk({tag, "_mode_cont"}, 32'(mode_cont), 0);
    chk({tag, "_hist_cnt"}, 32'(hist_cnt), 0);
    chk({tag, "_hist_sad"}, 32'(hist_sad), 0);
    chk({tag, "_hist_cyc"}, 32'(hist_cyc), 0);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick(2);
    chk_zero("reset");
    RSTN = 1'b1;
    tick(2);
  endtask

  task automatic press(input bit st, input bit sp, input bit md);
    if (st) sw_start_n = 1'b0;
    if (sp) sw_stop_n  = 1'b0;
    if (md) sw_mode_n  = 1'b0;
    tick(10);
    sw_start_n = 1'b1;
    sw_stop_n  = 1'b1;
    sw_mode_n  = 1'b1;
    tick(12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int rise, r0, t;

  initial begin
    tick(1);
    do_reset();

    // Debounce: a short glitch is ignored, a clean press gives one run.
    n_ack   = 3;
    cur_cnt = 12'h0AA;
    cur_sad = 16'h00BB;
    sw_start_n = 1'b0;
    tick(2);
    sw_start_n = 1'b1;
    tick(15);
    chk("glitch_no_run", req_rises, 0);
    rise = 0;
    sw_start_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (me_req && rise == 0) rise = i;
      @(posedge clk);
      #2;
      if (i == 10) sw_start_n = 1'b1;
    end
    chk("press_to_req_negedges", rise, 8);
    chk("clean_press_one_run", req_rises, 1);
    chk("db_run_count", 32'(run_count), 1);
    chk("db_hist_cnt", 32'(hist_cnt), 32'h0AA);
    chk("db_hist_cyc", 32'(hist_cyc), 3);
    chk("db_req_len", last_len, 4);

    // Single shot, then reading past the fill level.
    do_reset();
    n_ack   = 20;
    cur_cnt = 12'h123;
    cur_sad = 16'h0456;
    press(1'b1, 1'b0, 1'b0);
    tick(40);
    chk("ss_hist_cnt", 32'(hist_cnt), 32'h123);
    chk("ss_hist_sad", 32'(hist_sad), 32'h0456);
    chk("ss_hist_cyc", 32'(hist_cyc), 20);
    chk("ss_run_count", 32'(run_count), 1);
    chk("ss_busy", 32'(busy), 0);
    chk("ss_me_req", 32'(me_req), 0);
    chk("ss_req_rises", req_rises, 1);
    chk("ss_req_len", last_len, 21);
    hist_sel = 2'd2;
    tick(2);
    chk("empty_sel_cnt", 32'(hist_cnt), 0);
    chk("empty_sel_sad", 32'(hist_sad), 0);
    chk("empty_sel_cyc", 32'(hist_cyc), 0);
    hist_sel = 2'd0;
    tick(2);
    r0 = req_rises;
    press(1'b1, 1'b1, 1'b0);
    tick(10);
    chk("simul_no_run", req_rises - r0, 0);
    chk("simul_busy", 32'(busy), 0);
    chk("simul_run_count", 32'(run_count), 1);

    // Continuous mode: six back-to-back runs, then stop mid-run.
    do_reset();
    press(1'b0, 1'b0, 1'b1);
    chk("cont_mode_on", 32'(mode_cont), 1);
    n_ack   = 5;
    cur_cnt = 12'h201;
    cur_sad = 16'h1001;
    press(1'b1, 1'b0, 1'b0);
    t = 0;
    while (m_runs != 16'd6 && t < 300) begin
      tick(1);
      t++;
    end
    chk("cont_six_runs", 32'(m_runs), 6);
    n_ack = 40;
    press(1'b0, 1'b1, 1'b0);
    tick(20);
    chk("cont_busy", 32'(busy), 0);
    chk("cont_run_count", 32'(run_count), 6);
    chk("cont_fill", 32'(hist_fill), 4);
    chk("cont_wrapped", 32'(hist_wrapped), 1);
    chk("cont_req_rises", req_rises, 7);
    hist_sel = 2'd3;
    tick(2);
    chk("cont_sel3_cnt", 32'(hist_cnt), 32'h203);
    chk("cont_sel3_sad", 32'(hist_sad), 32'h1003);
    chk("cont_sel3_cyc", 32'(hist_cyc), 5);
    hist_sel = 2'd0;
    tick(2);
    chk("cont_sel0_cnt", 32'(hist_cnt), 32'h206);

    // Asynchronous reset in the middle of a run.
    never_ack = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    chk("pre_reset_req", 32'(me_req), 1);
    RSTN = 1'b0;
    #1;
    chk_zero("midrun");
    tick(2);
    RSTN = 1'b1;
    tick(3);
    chk("post_reset_busy", 32'(busy), 0);
    chk("post_reset_req", 32'(me_req), 0);

    // Timeout: no restart in continuous mode; next start clears the flag.
    do_reset();
    never_ack = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    chk("to_mode_on", 32'(mode_cont), 1);
    press(1'b1, 1'b0, 1'b0);
    tick(90);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_me_req", 32'(me_req), 0);
    chk("to_run_count", 32'(run_count), 0);
    chk("to_req_len", last_len, 64);
    chk("to_no_restart", req_rises, 1);
    press(1'b0, 1'b0, 1'b1);
    chk("to_mode_off", 32'(mode_cont), 0);
    chk("to_err_held", 32'(err_timeout), 1);
    never_ack = 1'b0;
    n_ack     = 2;
    cur_cnt   = 12'h3AB;
    cur_sad   = 16'h0CDE;
    press(1'b1, 1'b0, 1'b0);
    chk("to_err_cleared", 32'(err_timeout), 0);
    tick(10);
    chk("to_after_run_count", 32'(run_count), 1);
    chk("to_after_cnt", 32'(hist_cnt), 32'h3AB);
    chk("to_after_cyc", 32'(hist_cyc), 2);
    chk("to_after_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
